// File: rtl/ddr_cmd_issuer.sv
// Single-open-row DDR5 command issuer: decodes requests into ACT/RD/WR/PRE with tRCD/tCCD/tRP spacing.
// Optional DDR_OPEN_TIMEOUT_EN: precharge an open row after T_IDLE_PRE idle cycles in OPEN.
module ddr_cmd_issuer #(
  parameter int COL_W      = 11,
  parameter int BANK_W     = 5,
  parameter int ROW_W      = 16,
  parameter int T_RCD      = 4,
  parameter int T_CCD      = 2,
  parameter int T_RP       = 3,
  parameter int T_IDLE_PRE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       adrs_in,
  input  logic              op,
  input  logic              rd_valid,
  input  logic              wr_valid,
  input  logic              ppl,
  output logic              ready,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [COL_W-1:0]  cmd_col
);

  localparam int MAX_A = (T_RCD > T_CCD) ? T_RCD : T_CCD;
  localparam int MAX_B = (MAX_A > T_RP) ? MAX_A : T_RP;
  localparam int MAX_T = (MAX_B > T_IDLE_PRE) ? MAX_B : T_IDLE_PRE;
  localparam int CW    = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {S_IDLE, S_ACT_WAIT, S_CAS_GAP, S_OPEN, S_PRE_WAIT} state_e;
  typedef enum logic [2:0] {CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2,
                            CMD_WR = 3'd3, CMD_PRE = 3'd4} cmd_e;

  state_e            r_state, w_state_nxt;
  cmd_e              r_cmd, w_cmd_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_pend, w_pend_nxt;
  logic              r_ready, r_cmd_vld;
  logic [ROW_W-1:0]  r_row, r_orow, r_cmd_row, w_row_o;
  logic [BANK_W-1:0] r_bank, r_obank, r_cmd_bank, w_bank_o;
  logic [COL_W-1:0]  r_col, r_cmd_col, w_col_o;
  logic              r_op, r_ppl;
  logic              w_acc, w_open_ld, w_hit;
  logic [ROW_W-1:0]  w_a_row;
  logic [BANK_W-1:0] w_a_bank;
  logic [COL_W-1:0]  w_a_col;
`ifdef DDR_OPEN_TIMEOUT_EN
  logic [CW-1:0]     r_idle, w_idle_nxt;
`endif

  assign w_a_col  = adrs_in[COL_W-1:0];
  assign w_a_bank = adrs_in[COL_W +: BANK_W];
  assign w_a_row  = adrs_in[31 -: ROW_W];
  // Only the valid matching op counts; the other direction is ignored.
  assign w_acc    = r_ready & (op ? wr_valid : rd_valid);
  assign w_hit    = (w_a_row == r_orow) && (w_a_bank == r_obank);

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = CMD_NOP;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_open_ld   = 1'b0;
    w_row_o     = r_cmd_row;
    w_bank_o    = r_cmd_bank;
    w_col_o     = r_cmd_col;
`ifdef DDR_OPEN_TIMEOUT_EN
    w_idle_nxt  = r_idle;
`endif
    case (r_state)
      S_IDLE: if (w_acc) begin
        w_state_nxt = S_ACT_WAIT;
        w_cmd_nxt   = CMD_ACT;
        w_cnt_nxt   = CW'(T_RCD - 1);
        w_row_o     = w_a_row;
        w_bank_o    = w_a_bank;
      end
      S_ACT_WAIT: if (r_cnt == '0) begin
        w_state_nxt = S_CAS_GAP;
        w_cmd_nxt   = r_op ? CMD_WR : CMD_RD;
        w_cnt_nxt   = CW'(T_CCD - 1);
        w_bank_o    = r_bank;
        w_col_o     = r_col;
      end else begin
        w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_CAS_GAP: if (r_cnt == '0) begin
        if (r_ppl) begin
          w_state_nxt = S_OPEN;
          w_open_ld   = 1'b1;
`ifdef DDR_OPEN_TIMEOUT_EN
          w_idle_nxt  = '0;
`endif
        end else begin
          w_state_nxt = S_PRE_WAIT;
          w_cmd_nxt   = CMD_PRE;
          w_cnt_nxt   = CW'(T_RP - 1);
          w_bank_o    = r_bank;
        end
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
      S_OPEN: begin
        if (w_acc) begin
`ifdef DDR_OPEN_TIMEOUT_EN
          w_idle_nxt = '0;
`endif
          if (w_hit) begin
            w_state_nxt = S_CAS_GAP;
            w_cmd_nxt   = op ? CMD_WR : CMD_RD;
            w_cnt_nxt   = CW'(T_CCD - 1);
            w_bank_o    = w_a_bank;
            w_col_o     = w_a_col;
          end else begin
            // Close the open bank first; the new request is replayed from PRE_WAIT.
            w_state_nxt = S_PRE_WAIT;
            w_cmd_nxt   = CMD_PRE;
            w_cnt_nxt   = CW'(T_RP - 1);
            w_bank_o    = r_obank;
            w_pend_nxt  = 1'b1;
          end
        end
`ifdef DDR_OPEN_TIMEOUT_EN
        else if (r_idle == CW'(T_IDLE_PRE - 1)) begin
          w_state_nxt = S_PRE_WAIT;
          w_cmd_nxt   = CMD_PRE;
          w_cnt_nxt   = CW'(T_RP - 1);
          w_bank_o    = r_obank;
        end else begin
          w_idle_nxt  = r_idle + CW'(1);
        end
`endif
      end
      S_PRE_WAIT: if (r_cnt == '0) begin
        if (r_pend) begin
          w_state_nxt = S_ACT_WAIT;
          w_cmd_nxt   = CMD_ACT;
          w_cnt_nxt   = CW'(T_RCD - 1);
          w_row_o     = r_row;
          w_bank_o    = r_bank;
          w_pend_nxt  = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= CMD_NOP;
      r_cmd_vld  <= 1'b0;
      r_ready    <= 1'b0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_row      <= '0;
      r_bank     <= '0;
      r_col      <= '0;
      r_op       <= 1'b0;
      r_ppl      <= 1'b0;
      r_orow     <= '0;
      r_obank    <= '0;
      r_cmd_row  <= '0;
      r_cmd_bank <= '0;
      r_cmd_col  <= '0;
`ifdef DDR_OPEN_TIMEOUT_EN
      r_idle     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cmd      <= w_cmd_nxt;
      r_cmd_vld  <= (w_cmd_nxt != CMD_NOP);
      r_ready    <= ((w_state_nxt == S_IDLE) || (w_state_nxt == S_OPEN)) && !w_pend_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_cmd_row  <= w_row_o;
      r_cmd_bank <= w_bank_o;
      r_cmd_col  <= w_col_o;
`ifdef DDR_OPEN_TIMEOUT_EN
      r_idle     <= w_idle_nxt;
`endif
      if (w_acc) begin
        r_row  <= w_a_row;
        r_bank <= w_a_bank;
        r_col  <= w_a_col;
        r_op   <= op;
        r_ppl  <= ppl;
      end
      if (w_open_ld) begin
        r_orow  <= r_row;
        r_obank <= r_bank;
      end
    end
  end

  assign ready     = r_ready;
  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_vld;
  assign cmd_row   = r_cmd_row;
  assign cmd_bank  = r_cmd_bank;
  assign cmd_col   = r_cmd_col;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Scoreboard bench for ddr_cmd_issuer: expected commands (with issue cycle) queued at accept time.
module tb_ddr_cmd_issuer;
  localparam logic [2:0] ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4;

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] adrs_in = '0;
  logic        op = 1'b0, rd_valid = 1'b0, wr_valid = 1'b0, ppl = 1'b0;
  logic        ready, cmd_valid;
  logic [2:0]  cmd;
  logic [15:0] cmd_row;
  logic [4:0]  cmd_bank;
  logic [10:0] cmd_col;

  int n_chk = 0, n_err = 0, cyc = 0;

  typedef struct {
    logic [2:0]  c;
    logic [15:0] row;
    logic [4:0]  bank;
    logic [10:0] col;
    int          cy;
  } exp_t;
  exp_t q[$];

  ddr_cmd_issuer dut (
    .clk(clk), .rst(rst), .adrs_in(adrs_in), .op(op), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .ppl(ppl), .ready(ready), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_row(cmd_row), .cmd_bank(cmd_bank), .cmd_col(cmd_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void push(input logic [2:0] c, input logic [15:0] row,
                               input logic [4:0] bank, input logic [10:0] col, input int cy);
    exp_t e;
    e.c = c; e.row = row; e.bank = bank; e.col = col; e.cy = cy;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst && cmd_valid) begin
      if (q.size() == 0) begin
        chk("extra_cmd", {29'd0, cmd}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("cmd", {29'd0, cmd}, {29'd0, e.c});
        chk("cmd_cycle", cyc, e.cy);
        chk("cmd_bank", {27'd0, cmd_bank}, {27'd0, e.bank});
        if (e.c == ACT) chk("cmd_row", {16'd0, cmd_row}, {16'd0, e.row});
        if (e.c == RD || e.c == WR) chk("cmd_col", {21'd0, cmd_col}, {21'd0, e.col});
      end
    end
  end

  // Waits (bounded) for ready at a negedge, then drives one request; t = accept cycle.
  task automatic send(input logic [31:0] a, input logic o, input logic p,
                      input logic rv, input logic wv, output int t);
    int n;
    n = 0;
    @(negedge clk);
    rd_valid = 1'b0; wr_valid = 1'b0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_wait", {31'd0, ready}, 32'd1);
    adrs_in = a; op = o; ppl = p; rd_valid = rv; wr_valid = wv;
    t = cyc;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      rd_valid = 1'b0; wr_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      rd_valid = 1'b0; wr_valid = 1'b0;
      n++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin
    int t0, t1, t2;
    // reset state
    step(3);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_cmd", {29'd0, cmd}, 32'd0);
    chk("rst_vld", {31'd0, cmd_valid}, 32'd0);
    chk("rst_fields", {cmd_row, cmd_bank, cmd_col}, 32'd0);
    rst = 1'b1;
    step(1);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);

    // read, no page hint
    send(32'h0012_3456, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    push(ACT, 16'h0012, 5'd6, 11'h0, t0 + 1);
    push(RD, 16'h0, 5'd6, 11'h456, t0 + 5);
    push(PRE, 16'h0, 5'd6, 11'h0, t0 + 7);
    for (int c = 1; c <= 10; c++) begin
      step(1);
      chk("t1_ready", {31'd0, ready}, {31'd0, c == 10});
    end
    drain();

    // page hit: open with ppl=1, second write lands on the same row
    send(32'h0012_3456, 1'b1, 1'b1, 1'b0, 1'b1, t0);
    push(ACT, 16'h0012, 5'd6, 11'h0, t0 + 1);
    push(WR, 16'h0, 5'd6, 11'h456, t0 + 5);
    send(32'h0012_3457, 1'b1, 1'b1, 1'b0, 1'b1, t1);
    chk("hit_accept_cycle", t1 - t0, 32'd7);
    push(WR, 16'h0, 5'd6, 11'h457, t0 + 8);

    // page miss from OPEN (row 0x0012 bank 6 still open)
    send(32'h0013_3456, 1'b1, 1'b0, 1'b0, 1'b1, t2);
    chk("miss_accept_cycle", t2 - t0, 32'd10);
    push(PRE, 16'h0, 5'd6, 11'h0, t2 + 1);
    push(ACT, 16'h0013, 5'd6, 11'h0, t2 + 4);
    push(WR, 16'h0, 5'd6, 11'h456, t2 + 8);
    push(PRE, 16'h0, 5'd6, 11'h0, t2 + 10);
    for (int c = 1; c <= 13; c++) begin
      step(1);
      chk("miss_ready", {31'd0, ready}, {31'd0, c == 13});
    end
    drain();

    // both valids with op=0: read only
    send(32'h0ABC_1234, 1'b0, 1'b0, 1'b1, 1'b1, t0);
    push(ACT, 16'h0ABC, 5'd2, 11'h0, t0 + 1);
    push(RD, 16'h0, 5'd2, 11'h234, t0 + 5);
    push(PRE, 16'h0, 5'd2, 11'h0, t0 + 7);
    drain();
    step(4);

    // op=1 with only rd_valid: must not be accepted
    send(32'h0012_3456, 1'b1, 1'b0, 1'b1, 1'b0, t0);
    repeat (5) @(negedge clk);
    chk("wrong_valid_ready", {31'd0, ready}, 32'd1);
    step(5);
    chk("wrong_valid_q", q.size(), 32'd0);

    // async reset during ACT_WAIT
    send(32'h0012_3456, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    push(ACT, 16'h0012, 5'd6, 11'h0, t0 + 1);
    step(2);
    rst = 1'b0;
    #1;
    chk("midrst_cmd", {29'd0, cmd}, 32'd0);
    chk("midrst_vld", {31'd0, cmd_valid}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    step(2);
    rst = 1'b1;
    step(1);
    chk("midrst_release_ready", {31'd0, ready}, 32'd1);
    step(10);
    chk("midrst_q", q.size(), 32'd0);

    // open row left idle for a long time
    send(32'h0012_3456, 1'b0, 1'b1, 1'b1, 1'b0, t0);
    push(ACT, 16'h0012, 5'd6, 11'h0, t0 + 1);
    push(RD, 16'h0, 5'd6, 11'h456, t0 + 5);
`ifdef DDR_OPEN_TIMEOUT_EN
    push(PRE, 16'h0, 5'd6, 11'h0, t0 + 15);
`endif
    step(110);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_q", q.size(), 32'd0);
    send(32'h0012_3400, 1'b0, 1'b0, 1'b1, 1'b0, t1);
`ifdef DDR_OPEN_TIMEOUT_EN
    push(ACT, 16'h0012, 5'd6, 11'h0, t1 + 1);
    push(RD, 16'h0, 5'd6, 11'h400, t1 + 5);
    push(PRE, 16'h0, 5'd6, 11'h0, t1 + 7);
`else
    push(RD, 16'h0, 5'd6, 11'h400, t1 + 1);
    push(PRE, 16'h0, 5'd6, 11'h0, t1 + 3);
`endif
    drain();
    step(12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ddr_cmd_issuer.md
Name: ddr_cmd_issuer

Overview:
- Downstream responder for the read/write address pipeline stage.
- Consumes its address stream (adrs_in, op, rd_valid/wr_valid, ppl) and drives the ready back-pressure it samples.
- Decodes each address into row/bank/column and issues timed DDR5 ACT / RD / WR / PRE commands toward the PHY command path.
- Holds one open row; ppl=1 means "keep page open" for the next access.

Parameters:
- COL_W, 11: column field width, adrs_in[COL_W-1:0]
- BANK_W, 5: bank field width, next bits above column
- ROW_W, 16: row field width, top bits; COL_W+BANK_W+ROW_W must equal 32
- T_RCD, 4: ACT-to-CAS cycles, minimum 1
- T_CCD, 2: CAS-to-next-command cycles, minimum 1
- T_RP, 3: PRE-to-ACT/ready cycles, minimum 1
- T_IDLE_PRE, 8: idle cycles in OPEN before auto-precharge (feature only)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- adrs_in  in  32  request address from pipeline stage
- op  in  1  1=write, 0=read
- rd_valid  in  1  read address valid
- wr_valid  in  1  write address valid
- ppl  in  1  keep-page-open hint for this request
- ready  out  1  responder can accept a request this cycle
- cmd  out  3  0=NOP 1=ACT 2=RD 3=WR 4=PRE
- cmd_valid  out  1  cmd != NOP
- cmd_row  out  ROW_W  row for ACT
- cmd_bank  out  BANK_W  bank for ACT/RD/WR/PRE
- cmd_col  out  COL_W  column for RD/WR

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; pending, open-row, page-hint and counters cleared. Reset mid-operation abandons the request with no PRE issued.
- All outputs are registered. ready = (next_state in {IDLE, OPEN}) and not pending.
- Accept = ready & (op ? wr_valid : rd_valid). The opposite-direction valid is ignored. adrs_in, op and ppl are latched on accept.
- States:
  - IDLE: on accept, next cycle issue ACT (latched row/bank) -> ACT_WAIT.
  - ACT_WAIT: count T_RCD-1 cycles of NOP, then issue RD/WR -> CAS_GAP. With T_RCD=1 the CAS follows ACT directly.
  - CAS_GAP: count T_CCD-1 cycles of NOP.
    - If latched ppl=1: -> OPEN, remembering row/bank.
    - Else: issue PRE -> PRE_WAIT.
  - OPEN: ready=1. On accept, compare row+bank with the open row/bank.
    - Hit: issue RD/WR next cycle -> CAS_GAP (no ACT).
    - Miss: issue PRE for the open bank next cycle, set pending -> PRE_WAIT.
  - PRE_WAIT: count T_RP-1 cycles of NOP.
    - If pending: issue ACT for the pending request -> ACT_WAIT, clear pending.
    - Else: -> IDLE.
- Timing from accept in cycle 0 (miss from IDLE):
  - ACT in cycle 1
  - CAS in cycle 1+T_RCD
  - PRE in cycle 1+T_RCD+T_CCD
  - ready in cycle 1+T_RCD+T_CCD+T_RP
- cmd_row/bank/col hold their last values between commands. cmd_valid is 1 for exactly one cycle per command.
- Counters are sized to clog2(max timing parameter + 1) and do not wrap. A wait of 0 extra cycles is legal.

Optional Feature:
- Macro: DDR_OPEN_TIMEOUT_EN.
- Defined: an idle counter runs in OPEN and resets on accept. At T_IDLE_PRE consecutive idle cycles, PRE is issued for the open bank -> PRE_WAIT -> IDLE. ready is 0 from the cycle PRE issues.
- Not defined: the row stays open in OPEN indefinitely until a miss occurs.

Test Plan:
- Reset: assert rst=0 during ACT_WAIT -> cmd=0, cmd_valid=0, ready=0 immediately; ready=1 on first cycle after release.
- Read, no page hint: adrs_in=32'h0012_3456, op=0, ppl=0 (T_RCD=4, T_CCD=2, T_RP=3), accept at cycle 0 -> responses:
  - cycle 1: ACT, row=0x0012, bank=6
  - cycle 5: RD, col=0x456
  - cycle 7: PRE, bank 6
  - cycle 10: ready=1
- Page hit: write to 32'h0012_3456 with ppl=1, then at cycle 7 a write to 32'h0012_3457 -> WR in cycle 5, ready=1 in cycle 7, second WR col=0x457 in cycle 8 with no ACT.
- Page miss from OPEN: open row 0x0012 bank 6, request 32'h0013_3456 op=1 -> PRE cycle+1, ACT row=0x0013 at cycle+4, WR at cycle+8; ready=0 throughout.
- Both valids: rd_valid=wr_valid=1, op=0 -> RD issued; no WR ever issued for that cycle's request.
- Feature on (T_IDLE_PRE=8): OPEN with no requests -> PRE on 8th idle cycle, ready=1 again T_RP cycles later in IDLE. Feature off: no PRE after 100 idle cycles.
